// File: rtl/dmem_bus.sv
// Data-memory bus: word RAM, LED/switch I/O and a compare timer behind one CPU load/store port.
// Loads are combinational; stores and timer ticks update on the rising clock edge.
module dmem_bus #(
    parameter int DM_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    input  logic [15:0] sw,
    output logic [31:0] rdata,
    output logic [15:0] led,
    output logic        timer_irq
);
    localparam int AW = $clog2(DM_WORDS);

    logic [31:0]   ram [DM_WORDS];
    logic [31:0]   tcnt;
    logic [31:0]   tcmp;
    logic          en;
    logic          ar;
    logic          flag;

    logic [AW-1:0] word_idx;
    logic [2:0]    io_idx;
    logic          sel_ram;
    logic          sel_io;
    logic          wr_ram;
    logic          wr_led;
    logic          wr_tcnt;
    logic          wr_tcmp;
    logic          wr_tctl;
    logic          tick_match;
    logic          unused_addr_bits;

    assign word_idx = addr[AW+1:2];
    assign io_idx   = addr[4:2];
    assign sel_ram  = (addr[31:28] == 4'h0);
    assign sel_io   = (addr[31:28] == 4'hF);

    assign wr_ram  = mem_write && sel_ram;
    assign wr_led  = mem_write && sel_io && (io_idx == 3'd0);
    assign wr_tcnt = mem_write && sel_io && (io_idx == 3'd2);
    assign wr_tcmp = mem_write && sel_io && (io_idx == 3'd3);
    assign wr_tctl = mem_write && sel_io && (io_idx == 3'd4);

    // A TCNT store on this edge suppresses the compare entirely.
    assign tick_match = en && !wr_tcnt && (tcnt == tcmp);

    assign unused_addr_bits = ^{addr[27:AW+2], addr[1:0]};

    always_ff @(posedge clk) begin
        if (wr_ram)
            ram[word_idx] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led  <= 16'h0000;
            tcnt <= 32'h0000_0000;
            tcmp <= 32'hFFFF_FFFF;
            en   <= 1'b0;
            ar   <= 1'b0;
            flag <= 1'b0;
        end else begin
            if (wr_led)
                led <= wdata[15:0];
            if (wr_tcmp)
                tcmp <= wdata;

            if (wr_tcnt)
                tcnt <= wdata;
            else if (en) begin
                if (tcnt == tcmp) begin
                    if (ar)
                        tcnt <= 32'h0000_0000;
                end else begin
                    tcnt <= tcnt + 32'd1;
                end
            end

            // Software-written EN/AR beat the one-shot self-disable.
            if (wr_tctl) begin
                en <= wdata[0];
                ar <= wdata[1];
            end else if (tick_match && !ar) begin
                en <= 1'b0;
            end

            if (tick_match)
                flag <= 1'b1;
            else if (wr_tctl && wdata[2])
                flag <= 1'b0;
        end
    end

    always_comb begin
        rdata = 32'h0000_0000;
        if (sel_ram) begin
            rdata = ram[word_idx];
        end else if (sel_io) begin
            case (io_idx)
                3'd0:    rdata = {16'h0000, led};
                3'd1:    rdata = {16'h0000, sw};
                3'd2:    rdata = tcnt;
                3'd3:    rdata = tcmp;
                3'd4:    rdata = {29'b0, flag, ar, en};
                default: rdata = 32'h0000_0000;
            endcase
        end
    end

    assign timer_irq = flag;

endmodule
